wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone classic (B3) arbiter with round-robin grant and a bus watchdog.
Lets a second master (debug loader / DMA) share the SoC system bus with the picorv32 data master.
Sits between the masters and the address decoder.
Grant is held for the whole CYC burst. Stalled slave cycles are terminated with ERR after a programmable timeout.

---
 rtl/wb_arbiter_2m_pkg.sv | 15 +
 rtl/wb_arbiter_2m_if.sv | 27 ++
 rtl/wb_arbiter_2m_watchdog.sv | 30 +++
 rtl/wb_arbiter_2m.sv | 137 +++++++++++++
 tb/tb_wb_arbiter_2m.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the FSM state encoding and the one-hot grant codes.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle shared by masters and slave.
// master: drives adr/dat_w/sel/we/cyc/stb, receives dat_r/ack/err.
// slave:  receives adr/dat_w/sel/we/cyc/stb, drives dat_r/ack/err.
interface wb_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2m_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles and fires on the
// TIMEOUT-th one. Ports: clk, rst (sync high), stall, clear in; fire out.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clear,
    output logic fire
);
    // TIMEOUT of 0 or 1 still needs a 1-bit register to stay legal.
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] LAST = W'(LAST_I);
    localparam bit EN = (TIMEOUT > 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || !stall || fire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // With the watchdog disabled the counter just free-runs, unobserved.
    assign fire = EN && stall && (cnt == LAST);
endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B3 arbiter, round-robin, grant held for a CYC burst.
// Ports: wb_clk_i, wb_rst_i; m0/m1 bus (slave view); s bus (master view);
// grant_o one-hot current owner; timeout_o pulse after a watchdog abort.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_arbiter_2m_if.slave   m0,
    wb_arbiter_2m_if.slave   m1,
    wb_arbiter_2m_if.master  s,
    output logic [1:0]       grant_o,
    output logic             timeout_o
);
    state_t state_q, state_d;
    // last_q = 1 means m1 was served last, so m0 wins the next tie.
    logic last_q, last_d;

    logic            stall;
    logic            clear;
    logic            fire;

    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            timeout_o <= fire;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0.cyc) begin
                    state_d = ST_GNT0;
                end else if (m1.cyc) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0.cyc) begin
                    last_d  = 1'b0;
                    state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1.cyc) begin
                    last_d  = 1'b1;
                    state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        adr     = '0;
        dat     = '0;
        sel     = '0;
        we      = 1'b0;
        cyc     = 1'b0;
        stb     = 1'b0;
        grant_o = GRANT_NONE;
        unique case (state_q)
            ST_GNT0: begin
                adr     = m0.adr;
                dat     = m0.dat_w;
                sel     = m0.sel;
                we      = m0.we;
                cyc     = m0.cyc;
                stb     = m0.stb;
                grant_o = GRANT_M0;
            end
            ST_GNT1: begin
                adr     = m1.adr;
                dat     = m1.dat_w;
                sel     = m1.sel;
                we      = m1.we;
                cyc     = m1.cyc;
                stb     = m1.stb;
                grant_o = GRANT_M1;
            end
            default: begin
            end
        endcase
    end

    assign stall = (state_q != ST_IDLE) && stb && !s.ack && !s.err;
    assign clear = (state_d != state_q);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .stall (stall),
        .clear (clear),
        .fire  (fire)
    );

    // A watchdog abort withdraws the cycle from the slave in the same clock.
    assign s.adr   = adr;
    assign s.dat_w = dat;
    assign s.sel   = sel;
    assign s.we    = we;
    assign s.cyc   = cyc & ~fire;
    assign s.stb   = stb & ~fire;

    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    assign m0.ack = (state_q == ST_GNT0) & s.ack & m0.stb;
    assign m1.ack = (state_q == ST_GNT1) & s.ack & m1.stb;
    assign m0.err = (state_q == ST_GNT0) & (s.err | fire) & m0.stb;
    assign m1.err = (state_q == ST_GNT1) & (s.err | fire) & m1.stb;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: one DUT with TIMEOUT=8, one with
// the watchdog disabled. Inputs change 1ns after posedge, checks at +2ns.
module tb_wb_arbiter_2m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] grant_a, grant_b;
    logic tmo_a, tmo_b;
    int passed = 0;
    int total = 0;

    wb_arbiter_2m_if #(.AW(32), .DW(32)) m0a ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) m1a ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) sa ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) m0b ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) m1b ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) sb ();

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .m0 (m0a), .m1 (m1a), .s (sa),
        .grant_o (grant_a), .timeout_o (tmo_a)
    );

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(0)) dut_nw (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .m0 (m0b), .m1 (m1b), .s (sb),
        .grant_o (grant_b), .timeout_o (tmo_b)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0a.adr = '0; m0a.dat_w = '0; m0a.sel = '0; m0a.we = 0; m0a.cyc = 0; m0a.stb = 0;
        m1a.adr = '0; m1a.dat_w = '0; m1a.sel = '0; m1a.we = 0; m1a.cyc = 0; m1a.stb = 0;
        m0b.adr = '0; m0b.dat_w = '0; m0b.sel = '0; m0b.we = 0; m0b.cyc = 0; m0b.stb = 0;
        m1b.adr = '0; m1b.dat_w = '0; m1b.sel = '0; m1b.we = 0; m1b.cyc = 0; m1b.stb = 0;
        sa.dat_r = '0; sa.ack = 0; sa.err = 0;
        sb.dat_r = '0; sb.ack = 0; sb.err = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        #1;
        total++; if (grant_a !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant_a); else passed++;
        total++; if ({sa.cyc, sa.stb, sa.we} !== 3'b000) $display("FAIL rst_slave: got %b want 000", {sa.cyc, sa.stb, sa.we}); else passed++;
        total++; if ({m0a.ack, m0a.err, m1a.ack, m1a.err} !== 4'b0) $display("FAIL rst_ackerr: got %b want 0000", {m0a.ack, m0a.err, m1a.ack, m1a.err}); else passed++;
        total++; if (tmo_a !== 1'b0) $display("FAIL rst_timeout: got %b want 0", tmo_a); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single;
        m0a.cyc = 1; m0a.stb = 1; m0a.adr = 32'h0000_0010; m0a.sel = 4'hF;
        #1;
        total++; if (sa.cyc !== 1'b0) $display("FAIL single_cyc_early: got %b want 0", sa.cyc); else passed++;
        step();
        #1;
        total++; if (sa.cyc !== 1'b1) $display("FAIL single_cyc_rise: got %b want 1", sa.cyc); else passed++;
        total++; if (grant_a !== 2'b01) $display("FAIL single_grant: got %b want 01", grant_a); else passed++;
        total++; if (sa.adr !== 32'h10) $display("FAIL single_adr: got %h want 00000010", sa.adr); else passed++;
        step();
        #1;
        total++; if (m0a.ack !== 1'b0) $display("FAIL single_noack: got %b want 0", m0a.ack); else passed++;
        step();
        sa.ack = 1; sa.dat_r = 32'hDEAD_BEEF;
        #1;
        total++; if (m0a.ack !== 1'b1) $display("FAIL single_ack: got %b want 1", m0a.ack); else passed++;
        total++; if (m0a.dat_r !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h want deadbeef", m0a.dat_r); else passed++;
        total++; if (m1a.ack !== 1'b0) $display("FAIL single_m1ack: got %b want 0", m1a.ack); else passed++;
        step();
        sa.ack = 0; m0a.cyc = 0; m0a.stb = 0;
        #1;
        total++; if ({sa.cyc, m0a.ack} !== 2'b00) $display("FAIL single_drop: got %b want 00", {sa.cyc, m0a.ack}); else passed++;
        step();
        #1;
        total++; if (grant_a !== 2'b00) $display("FAIL single_idle: got %b want 00", grant_a); else passed++;
    endtask

    task automatic test_tie;
        rst = 1; step(); rst = 0;
        m0a.cyc = 1; m0a.stb = 1; m0a.adr = 32'h0000_0020;
        m1a.cyc = 1; m1a.stb = 1; m1a.adr = 32'h0000_0030;
        m1a.we = 1; m1a.dat_w = 32'h1234_5678; m1a.sel = 4'hF;
        step();
        sa.ack = 1;
        #1;
        total++; if (grant_a !== 2'b01) $display("FAIL tie_first: got %b want 01", grant_a); else passed++;
        total++; if ({m0a.ack, m1a.ack} !== 2'b10) $display("FAIL tie_ack0: got %b want 10", {m0a.ack, m1a.ack}); else passed++;
        step();
        sa.ack = 0; m0a.cyc = 0; m0a.stb = 0;
        step();
        #1;
        total++; if (grant_a !== 2'b10) $display("FAIL tie_switch: got %b want 10", grant_a); else passed++;
        total++; if ({sa.cyc, sa.we, sa.sel} !== 6'b11_1111) $display("FAIL tie_ctl: got %b want 111111", {sa.cyc, sa.we, sa.sel}); else passed++;
        total++; if (sa.dat_w !== 32'h1234_5678) $display("FAIL tie_wdata: got %h want 12345678", sa.dat_w); else passed++;
        total++; if (sa.adr !== 32'h30) $display("FAIL tie_adr: got %h want 00000030", sa.adr); else passed++;
        sa.ack = 1;
        #1;
        total++; if ({m0a.ack, m1a.ack} !== 2'b01) $display("FAIL tie_ack1: got %b want 01", {m0a.ack, m1a.ack}); else passed++;
        step();
        sa.ack = 0; m1a.cyc = 0; m1a.stb = 0; m1a.we = 0;
        step();
        #1;
        total++; if (grant_a !== 2'b00) $display("FAIL tie_idle: got %b want 00", grant_a); else passed++;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        m0a.cyc = 1; m0a.stb = 1;
        m1a.cyc = 1; m1a.stb = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            m0a.cyc = 1; m0a.stb = 1;
            m1a.cyc = 1; m1a.stb = 1;
            sa.ack = 1;
            #1;
            total++; if (grant_a !== exp) $display("FAIL rr_grant%0d: got %b want %b", i, grant_a, exp); else passed++;
            total++; if ({m1a.ack, m0a.ack} !== exp) $display("FAIL rr_ack%0d: got %b want %b", i, {m1a.ack, m0a.ack}, exp); else passed++;
            step();
            sa.ack = 0;
            if (exp == 2'b01) begin m0a.cyc = 0; m0a.stb = 0; end
            else begin m1a.cyc = 0; m1a.stb = 0; end
            step();
        end
        idle_inputs();
        step();
        step();
        #1;
        total++; if (grant_a !== 2'b00) $display("FAIL rr_idle: got %b want 00", grant_a); else passed++;
    endtask

    task automatic test_watchdog;
        int early;
        early = 0;
        m1a.cyc = 1; m1a.stb = 1; m1a.adr = 32'h0000_0040;
        step();
        for (int k = 1; k < 8; k++) begin
            #1;
            if (m1a.err !== 1'b0 || sa.stb !== 1'b1) early++;
            step();
        end
        total++; if (early !== 0) $display("FAIL wd_early: got %0d bad cycles want 0", early); else passed++;
        #1;
        total++; if (m1a.err !== 1'b1) $display("FAIL wd_err: got %b want 1", m1a.err); else passed++;
        total++; if ({sa.stb, sa.cyc} !== 2'b00) $display("FAIL wd_abort: got %b want 00", {sa.stb, sa.cyc}); else passed++;
        total++; if ({m0a.ack, m0a.err} !== 2'b00) $display("FAIL wd_m0: got %b want 00", {m0a.ack, m0a.err}); else passed++;
        total++; if (tmo_a !== 1'b0) $display("FAIL wd_tmo_early: got %b want 0", tmo_a); else passed++;
        total++; if (grant_a !== 2'b10) $display("FAIL wd_grant: got %b want 10", grant_a); else passed++;
        step();
        #1;
        total++; if (tmo_a !== 1'b1) $display("FAIL wd_tmo_pulse: got %b want 1", tmo_a); else passed++;
        total++; if ({m1a.err, sa.stb} !== 2'b01) $display("FAIL wd_after: got %b want 01", {m1a.err, sa.stb}); else passed++;
        step();
        #1;
        total++; if (tmo_a !== 1'b0) $display("FAIL wd_tmo_end: got %b want 0", tmo_a); else passed++;
        m1a.cyc = 0; m1a.stb = 0;
        step();
        #1;
        total++; if (grant_a !== 2'b00) $display("FAIL wd_idle: got %b want 00", grant_a); else passed++;
    endtask

    task automatic test_no_watchdog;
        int bad;
        bad = 0;
        m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'h0000_0080;
        step();
        for (int k = 0; k < 1000; k++) begin
            #1;
            if (m0b.err !== 1'b0 || tmo_b !== 1'b0 || sb.stb !== 1'b1) bad++;
            step();
        end
        total++; if (bad !== 0) $display("FAIL nowd_stall: got %0d bad cycles want 0", bad); else passed++;
        sb.ack = 1; sb.dat_r = 32'hCAFE_F00D;
        #1;
        total++; if (m0b.ack !== 1'b1) $display("FAIL nowd_ack: got %b want 1", m0b.ack); else passed++;
        total++; if (m0b.dat_r !== 32'hCAFE_F00D) $display("FAIL nowd_data: got %h want cafef00d", m0b.dat_r); else passed++;
        step();
        sb.ack = 0; m0b.cyc = 0; m0b.stb = 0;
        step();
        #1;
        total++; if (grant_b !== 2'b00) $display("FAIL nowd_idle: got %b want 00", grant_b); else passed++;
    endtask

    task automatic test_reset_mid;
        int early;
        early = 0;
        m0a.cyc = 1; m0a.stb = 1; m0a.adr = 32'h0000_0100;
        step();
        sa.ack = 1;
        #1;
        total++; if (m0a.ack !== 1'b1) $display("FAIL mid_beat1: got %b want 1", m0a.ack); else passed++;
        step();
        sa.ack = 0; sa.err = 1; m0a.adr = 32'h0000_0104;
        #1;
        total++; if (m0a.err !== 1'b1) $display("FAIL mid_err: got %b want 1", m0a.err); else passed++;
        step();
        sa.err = 0;
        #1;
        total++; if (grant_a !== 2'b01) $display("FAIL mid_err_hold: got %b want 01", grant_a); else passed++;
        sa.ack = 1; m0a.adr = 32'h0000_0108; rst = 1;
        step();
        #1;
        total++; if (grant_a !== 2'b00) $display("FAIL mid_grant: got %b want 00", grant_a); else passed++;
        total++; if ({sa.cyc, sa.stb, sa.adr} !== 34'b0) $display("FAIL mid_slave: got %h want 0", {sa.cyc, sa.stb, sa.adr}); else passed++;
        total++; if ({m0a.ack, m0a.err, tmo_a} !== 3'b000) $display("FAIL mid_ack_drop: got %b want 000", {m0a.ack, m0a.err, tmo_a}); else passed++;
        rst = 0; sa.ack = 0;
        m0a.cyc = 0; m0a.stb = 0;
        m1a.cyc = 1; m1a.stb = 1;
        step();
        #1;
        total++; if (grant_a !== 2'b10) $display("FAIL mid_m1_grant: got %b want 10", grant_a); else passed++;
        for (int k = 1; k < 8; k++) begin
            if (m1a.err !== 1'b0) early++;
            step();
            #1;
        end
        total++; if (early !== 0) $display("FAIL mid_wd_early: got %0d want 0", early); else passed++;
        total++; if (m1a.err !== 1'b1) $display("FAIL mid_wd_fire: got %b want 1", m1a.err); else passed++;
        m1a.cyc = 0; m1a.stb = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_watchdog();
        test_no_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
